// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Upstream sequencer for the 32-bit ALU. Accepts one operation request at a
//   time on a valid/ready handshake, presents registered operands/opcode to
//   the ALU, waits one cycle for combinational ops or for alu_done on the
//   multi-cycle mod (with a timeout), and returns result/carry/error on an
//   output valid/ready handshake.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_op          request operands and opcode
//                              (000 and,001 or,010 xor,011 nor,100 slt,
//                               101 add,110 sub,111 mod)
//   alu_a, alu_b, alu_op       registered operands/opcode to the ALU
//   alu_start                  one-cycle start pulse for mod
//   alu_res, alu_carry         ALU result and adder carry-out
//   alu_done                   ALU mod-complete flag
//   out_valid/out_ready        response handshake
//   out_data, out_carry        captured result; carry only for add
//   out_err                    mod by zero or mod timeout (out_data = 0)

module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic [31:0] alu_res,
  input  logic        alu_carry,
  input  logic        alu_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_carry,
  output logic        out_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]  OP_ADD = 3'b101;
  localparam logic [2:0]  OP_MOD = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MOD_START,
    WAIT_MOD,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     data_q, data_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    carry_d = carry_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d  = in_a;
          b_d  = in_b;
          op_d = in_op;
          if (in_op != OP_MOD) begin
            state_d = EXEC;
          end else if (in_b != '0) begin
            state_d = MOD_START;
          end else begin
            // Divide by zero is answered immediately; the ALU is never started.
            data_d  = '0;
            carry_d = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      EXEC: begin
        data_d  = alu_res;
        carry_d = (op_q == OP_ADD) ? alu_carry : 1'b0;
        err_d   = 1'b0;
        state_d = RESP;
      end

      // alu_done is not looked at here, so a done left over from the
      // previous mod cannot complete this one.
      MOD_START: begin
        cnt_d   = '0;
        state_d = WAIT_MOD;
      end

      WAIT_MOD: begin
        // Done is checked before the timeout so it wins a tie. Comparing the
        // pre-increment count against TIMEOUT_CYCLES-1 aborts on the cycle the
        // count would reach TIMEOUT_CYCLES.
        if (alu_done) begin
          data_d  = alu_res;
          carry_d = 1'b0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign alu_start = (state_q == MOD_START);
  assign out_valid = (state_q == RESP);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Directed testbench for alu_issue_ctrl. A small behavioural ALU answers the
//   combinational ops; mod completion is driven by hand from each test.

module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic [31:0] alu_res;
  logic        alu_carry;
  logic        alu_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_err;

  logic [31:0] mod_res;
  logic        mod_done;
  int          start_cnt = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_res   (alu_res),
    .alu_carry (alu_carry),
    .alu_done  (alu_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_err   (out_err)
  );

  // Behavioural ALU. Carry is deliberately 1 for non-add ops so that
  // masking in the controller is visible.
  logic [32:0] sum;
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b1;
    case (alu_op)
      3'b000: alu_res = alu_a & alu_b;
      3'b001: alu_res = alu_a | alu_b;
      3'b010: alu_res = alu_a ^ alu_b;
      3'b011: alu_res = ~(alu_a | alu_b);
      3'b100: alu_res = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      3'b101: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res   = sum[31:0];
        alu_carry = sum[32];
      end
      3'b110: begin
        sum       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res   = sum[31:0];
        alu_carry = sum[32];
      end
      default: alu_res = mod_res;
    endcase
  end
  assign alu_done = mod_done;

  always @(posedge clk) if (alu_start) start_cnt <= start_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request, accepted at the next posedge; inputs are then scrambled to
  // show that nothing is sampled while in_ready is low.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    tick();
    in_valid = 1'b0;
    in_a     = 32'hBAD0_BAD0;
    in_b     = 32'h0BAD_0BAD;
    in_op    = 3'b000;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1; in_op = 3'b101;
    tick(); tick();
    in_valid = 1'b0;
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL reset_alu_start: got %b expected 0", alu_start); end
    n_checks++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_fail++; $display("FAIL reset_alu_regs: got a=%h b=%h op=%b expected zeros", alu_a, alu_b, alu_op); end
    n_checks++; if ({out_data, out_carry, out_err} !== 34'd0) begin n_fail++; $display("FAIL reset_out_regs: got d=%h c=%b e=%b expected zeros", out_data, out_carry, out_err); end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] d;
    logic        c;
  } vec_t;

  task automatic test_comb_ops();
    vec_t v[9];
    v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 32'h0000_0000, 1'b1};
    v[1] = '{32'h0000_0005, 32'h0000_0007, 3'b110, 32'hFFFF_FFFE, 1'b0};
    v[2] = '{32'h0000_F0F0, 32'h0000_FFFF, 3'b010, 32'h0000_0F0F, 1'b0};
    v[3] = '{32'h0F0F_00FF, 32'h00FF_0F0F, 3'b000, 32'h000F_000F, 1'b0};
    v[4] = '{32'h1200_0034, 32'h0056_7800, 3'b001, 32'h1256_7834, 1'b0};
    v[5] = '{32'h0000_0000, 32'hFFFF_0000, 3'b011, 32'h0000_FFFF, 1'b0};
    v[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 32'h0000_0001, 1'b0};
    v[7] = '{32'h0000_0002, 32'h0000_0003, 3'b101, 32'h0000_0005, 1'b0};
    v[8] = '{32'h0000_0005, 32'hFFFF_FFFB, 3'b100, 32'h0000_0000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL comb%0d_ready: got %b expected 1", i, in_ready); end
      issue(v[i].a, v[i].b, v[i].op);
      n_checks++; if ({alu_a, alu_b, alu_op} !== {v[i].a, v[i].b, v[i].op}) begin n_fail++; $display("FAIL comb%0d_alu_in: got a=%h b=%h op=%b expected a=%h b=%h op=%b", i, alu_a, alu_b, alu_op, v[i].a, v[i].b, v[i].op); end
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL comb%0d_exec: got valid=%b ready=%b expected 0 0", i, out_valid, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL comb%0d_valid: got %b expected 1", i, out_valid); end
      n_checks++; if (out_data !== v[i].d) begin n_fail++; $display("FAIL comb%0d_data: got %h expected %h", i, out_data, v[i].d); end
      n_checks++; if (out_carry !== v[i].c || out_err !== 1'b0) begin n_fail++; $display("FAIL comb%0d_flags: got c=%b e=%b expected c=%b e=0", i, out_carry, out_err, v[i].c); end
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== v[i].d) begin n_fail++; $display("FAIL comb%0d_hold: got valid=%b data=%h expected 1 %h", i, out_valid, out_data, v[i].d); end
      consume();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL comb%0d_done: got valid=%b ready=%b expected 0 1", i, out_valid, in_ready); end
    end
  endtask

  // in_valid and out_ready held high: one accept every three cycles.
  task automatic test_back_to_back();
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd23; in_op = 3'b101;
    out_ready = 1'b1;
    tick();
    in_a = 32'd7; in_b = 32'd9; in_op = 3'b110;
    n_checks++; if (alu_a !== 32'd100 || in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept1: got a=%h ready=%b expected 64 0", alu_a, in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd123) begin n_fail++; $display("FAIL b2b_resp1: got valid=%b data=%h expected 1 7b", out_valid, out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 32'd100) begin n_fail++; $display("FAIL b2b_idle: got valid=%b ready=%b a=%h expected 0 1 64", out_valid, in_ready, alu_a); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (alu_a !== 32'd7 || alu_op !== 3'b110) begin n_fail++; $display("FAIL b2b_accept2: got a=%h op=%b expected 7 110", alu_a, alu_op); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFE || out_carry !== 1'b0) begin n_fail++; $display("FAIL b2b_resp2: got valid=%b data=%h c=%b expected 1 fffffffe 0", out_valid, out_data, out_carry); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_mod();
    int s0;
    bit early;
    s0 = start_cnt;
    mod_done = 1'b1;
    mod_res  = 32'hDEAD_BEEF;
    issue(32'd17, 32'd5, 3'b111);
    n_checks++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL mod_start_pulse: got %b expected 1", alu_start); end
    tick();
    mod_done = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || alu_start !== 1'b0) begin n_fail++; $display("FAIL mod_stale_done: got valid=%b start=%b expected 0 0", out_valid, alu_start); end
    early = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (out_valid !== 1'b0 || alu_start !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL mod_wait: got early response or start expected none"); end
    mod_res  = 32'd2;
    mod_done = 1'b1;
    tick();
    mod_done = 1'b0;
    mod_res  = 32'hDEAD_BEEF;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd2) begin n_fail++; $display("FAIL mod_result: got valid=%b data=%h expected 1 2", out_valid, out_data); end
    n_checks++; if (out_err !== 1'b0 || out_carry !== 1'b0) begin n_fail++; $display("FAIL mod_flags: got e=%b c=%b expected 0 0", out_err, out_carry); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL mod_start_count: got %0d expected 1", start_cnt - s0); end
    consume();
  endtask

  task automatic test_mod_zero();
    int s0;
    s0 = start_cnt;
    issue(32'd9, 32'd0, 3'b111);
    n_checks++; if (out_valid !== 1'b1 || alu_start !== 1'b0) begin n_fail++; $display("FAIL modz_resp: got valid=%b start=%b expected 1 0", out_valid, alu_start); end
    n_checks++; if (out_err !== 1'b1 || out_data !== 32'd0 || out_carry !== 1'b0) begin n_fail++; $display("FAIL modz_flags: got e=%b d=%h c=%b expected 1 0 0", out_err, out_data, out_carry); end
    consume();
    n_checks++; if (start_cnt - s0 !== 0) begin n_fail++; $display("FAIL modz_start_count: got %0d expected 0", start_cnt - s0); end
  endtask

  // 64 cycles in WAIT_MOD without done aborts; done on the 64th cycle wins.
  task automatic test_timeout();
    bit early;
    for (int pass = 0; pass < 2; pass++) begin
      mod_done = 1'b0;
      mod_res  = 32'h0000_1234;
      issue(32'd100, 32'd7, 3'b111);
      tick();
      early = 1'b0;
      for (int i = 0; i < 63; i++) begin
        tick();
        if (out_valid !== 1'b0) early = 1'b1;
      end
      n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL tmo%0d_early: got response before 64 wait cycles expected none", pass); end
      if (pass == 1) begin
        mod_res  = 32'd3;
        mod_done = 1'b1;
      end
      tick();
      mod_done = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL tmo%0d_valid: got %b expected 1", pass, out_valid); end
      if (pass == 0) begin
        n_checks++; if (out_err !== 1'b1 || out_data !== 32'd0) begin n_fail++; $display("FAIL tmo0_abort: got e=%b d=%h expected 1 0", out_err, out_data); end
      end else begin
        n_checks++; if (out_err !== 1'b0 || out_data !== 32'd3) begin n_fail++; $display("FAIL tmo1_done_wins: got e=%b d=%h expected 0 3", out_err, out_data); end
      end
      consume();
    end
  endtask

  task automatic test_hold_and_reset();
    bit moved;
    issue(32'h10, 32'h20, 3'b101);
    tick();
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      tick();
      if (out_valid !== 1'b1 || out_data !== 32'h30 || out_err !== 1'b0 || alu_a !== 32'h10) moved = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++; if (moved !== 1'b0) begin n_fail++; $display("FAIL hold_stable: got changing outputs expected stable 30"); end
    consume();
    mod_done = 1'b0;
    issue(32'd50, 32'd7, 3'b111);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got ready=%b valid=%b start=%b expected 1 0 0", in_ready, out_valid, alu_start); end
    n_checks++; if ({alu_a, alu_b, alu_op, out_data, out_carry, out_err} !== 101'd0) begin n_fail++; $display("FAIL rst_mid_regs: got a=%h b=%h op=%b d=%h expected zeros", alu_a, alu_b, alu_op, out_data); end
    mod_done = 1'b1;
    mod_res  = 32'd1;
    moved = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) moved = 1'b1;
    end
    mod_done = 1'b0;
    n_checks++; if (moved !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dropped: got a response expected none"); end
    issue(32'h0000_00FF, 32'h0000_0F0F, 3'b010);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0FF0) begin n_fail++; $display("FAIL rst_recover: got valid=%b data=%h expected 1 00000ff0", out_valid, out_data); end
    consume();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b0; mod_done = 1'b0; mod_res = '0;
    test_reset();
    test_comb_ops();
    test_back_to_back();
    test_mod();
    test_mod_zero();
    test_timeout();
    test_hold_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
